sonic_v1_15_pcs_eth_10g_mac_tx_st_timing_adapter: RTL

TX-side Avalon-ST timing adapter between the SoNIC PCS/host TX datapath and the 10G MAC TX streaming sink. It accepts 72-bit beats from a ready-latency-0 source and re-issues them to a sink that grants transfer slots with a configurable ready latency. A small FIFO absorbs the latency mismatch, and `in_ready` is fully registered so the upstream timing path is cut. Unlike the RX adapter, this direction supports backpressure end to end and never drops data.

---
 rtl/sonic_v1_15_pcs_eth_10g_mac_tx_st_timing_adapter.sv | 108 ++++++++++
 1 files changed

// File: rtl/sonic_v1_15_pcs_eth_10g_mac_tx_st_timing_adapter.sv
// TX Avalon-ST timing adapter: ready-latency-0 source to a READY_LATENCY sink through a small FIFO.
// Optional starvation counter enabled by SONIC_TX_TA_STATS_EN.
module sonic_v1_15_pcs_eth_10g_mac_tx_st_timing_adapter #(
  parameter int unsigned DATA_WIDTH    = 72,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned READY_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef SONIC_TX_TA_STATS_EN
  ,
  output logic [31:0]           stat_starve_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  in_ready_q;
  logic                  slot;
  logic                  push, pop;

  // Slot grant delayed by the sink's ready latency.
  if (READY_LATENCY == 0) begin : g_rl0
    assign slot = out_ready;
  end else begin : g_rl
    logic [READY_LATENCY-1:0] rdy_pipe_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rdy_pipe_q <= '0;
      end else begin
        for (int i = READY_LATENCY - 1; i > 0; i--) begin
          rdy_pipe_q[i] <= rdy_pipe_q[i-1];
        end
        rdy_pipe_q[0] <= out_ready;
      end
    end

    assign slot = rdy_pipe_q[READY_LATENCY-1];
  end

  always_comb begin
    push    = in_valid & in_ready_q;
    pop     = slot & (count_q != '0);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q    <= count_d;
      // Registered from next occupancy so upstream sees no combinational path.
      in_ready_q <= (count_d != DepthCnt);
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = pop;
  assign out_data  = mem_q[rd_ptr_q];

`ifdef SONIC_TX_TA_STATS_EN
  logic [31:0] starve_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else if (slot && (count_q == '0) && (starve_cnt_q != 32'hFFFF_FFFF)) begin
      starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign stat_starve_cnt = starve_cnt_q;
`endif

endmodule
